// File: rtl/reg_display_scan_if.sv
// reg_display_scan_if: cpu register inputs and seven-segment display outputs of the scan block
interface reg_display_scan_if;
    logic [7:0] reg0;
    logic [7:0] reg1;
    logic [7:0] reg2;
    logic [7:0] reg3;
    logic       hold;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output reg0, reg1, reg2, reg3, hold,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  reg0, reg1, reg2, reg3, hold,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/reg_display_scan.sv
// reg_display_scan: scans four cpu registers as eight hex digits on a common-anode display;
// define LEADING_ZERO_BLANK_EN to blank a register's high digit when its high nibble is zero
module reg_display_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input logic               clk,
    input logic               rst_n,
    reg_display_scan_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shadow [4];
    logic [31:0]   flat;
    logic [3:0]    nib;
    logic          term;
    logic          frame_end;
    logic          blank;
    logic          lead_zero;
    logic          off;

    assign term      = cnt == CW'(REFRESH_DIV - 1);
    assign frame_end = term && idx == 3'd7;
    assign flat      = {shadow[3], shadow[2], shadow[1], shadow[0]};
    assign nib       = flat[{idx, 2'b00} +: 4];

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank = 1'b0;
        end else begin : g_blank
            assign blank = cnt < CW'(BLANK_CYCLES);
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    assign lead_zero = idx[0] && nib == 4'h0;
`else
    assign lead_zero = 1'b0;
`endif

    assign off = blank || lead_zero;

    // slot divider and digit index, wrapping every 8*REFRESH_DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 3'd0;
        end else begin
            cnt <= term ? '0 : cnt + 1'b1;
            if (term) idx <= idx + 3'd1;
        end
    end

    // snapshot all registers together at the frame boundary so no frame mixes old and new values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) shadow[k] <= 8'h00;
        end else if (frame_end && !bus.hold) begin
            shadow[0] <= bus.reg0;
            shadow[1] <= bus.reg1;
            shadow[2] <= bus.reg2;
            shadow[3] <= bus.reg3;
        end
    end

    // registered display drive; separators light between registers in slots 2, 4 and 6
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an         <= 8'hFF;
            bus.seg        <= 7'h7F;
            bus.dp         <= 1'b1;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.an         <= off ? 8'hFF : ~(8'd1 << idx);
            bus.seg        <= off ? 7'h7F : HEX[nib];
            bus.dp         <= off || idx[0] || idx == 3'd0;
            bus.frame_tick <= frame_end;
        end
    end
endmodule

// File: tb/tb_reg_display_scan.sv
// tb_reg_display_scan: scoreboard bench for reg_display_scan with REFRESH_DIV=4, BLANK_CYCLES=1
module tb_reg_display_scan;
    typedef struct {
        int         tag;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
        string      name;
    } exp_t;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    reg_display_scan_if bus ();

    reg_display_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    exp_t e;
    int   n = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s at sample %0d: got %h, expected %h", name, field, n, act, exp);
        end
    endtask

    task automatic push(input int tag, input logic [7:0] an, input logic [6:0] seg,
                        input logic dp, input logic tick, input string name);
        exp_t x;
        x.tag = tag; x.an = an; x.seg = seg; x.dp = dp; x.tick = tick; x.name = name;
        q.push_back(x);
    endtask

    task automatic wait_n(input int t);
        for (int i = 0; i < 5000 && n < t; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // monitor: sample number n counts clock edges since reset release
    always @(negedge clk) begin
        if (!rst_n) n = 0;
        else n = n + 1;
        while (q.size() > 0 && q[0].tag <= n) begin
            e = q.pop_front();
            if (e.tag < n) begin
                checks++;
                errors++;
                $display("FAIL %s: sample %0d never observed, now at %0d", e.name, e.tag, n);
            end else begin
                chk(e.name, "an", int'(bus.an), int'(e.an));
                chk(e.name, "seg", int'(bus.seg), int'(e.seg));
                chk(e.name, "dp", int'(bus.dp), int'(e.dp));
                chk(e.name, "frame_tick", int'(bus.frame_tick), int'(e.tick));
            end
        end
    end

    initial begin
        bus.reg0 = 8'h00; bus.reg1 = 8'h00; bus.reg2 = 8'h00; bus.reg3 = 8'h00; bus.hold = 1'b0;
        push(0, 8'hFF, 7'h7F, 1'b1, 1'b0, "reset");
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        push(1,   8'hFF, 7'h7F, 1'b1, 1'b0, "s0_blank");
        push(2,   8'hFE, 7'h40, 1'b1, 1'b0, "s0_zero");
        push(31,  LZ ? 8'hFF : 8'h7F, LZ ? 7'h7F : 7'h40, 1'b1, 1'b0, "pre_tick");
        push(32,  LZ ? 8'hFF : 8'h7F, LZ ? 7'h7F : 7'h40, 1'b1, 1'b1, "tick1");
        push(33,  8'hFF, 7'h7F, 1'b1, 1'b0, "post_tick");
        push(34,  8'hFE, 7'h08, 1'b1, 1'b0, "reg0_lo");
        push(37,  8'hFF, 7'h7F, 1'b1, 1'b0, "s1_blank");
        push(38,  8'hFD, 7'h30, 1'b1, 1'b0, "reg0_hi");
        push(64,  LZ ? 8'hFF : 8'h7F, LZ ? 7'h7F : 7'h40, 1'b1, 1'b1, "tick2");
        push(65,  8'hFF, 7'h7F, 1'b1, 1'b0, "post_tick2");
        push(96,  LZ ? 8'hFF : 8'h7F, LZ ? 7'h7F : 7'h40, 1'b1, 1'b1, "tick3");
        push(106, 8'hFB, 7'h40, 1'b0, 1'b0, "held_d2");
        push(110, LZ ? 8'hFF : 8'hF7, LZ ? 7'h7F : 7'h40, 1'b1, 1'b0, "held_d3");
        push(138, 8'hFB, 7'h46, 1'b0, 1'b0, "reg1_lo");
        push(143, 8'hF7, 7'h12, 1'b1, 1'b0, "reg1_hi");
        rst_n = 1'b1;
        bus.reg0 = 8'h3A;
        wait_n(40);
        bus.hold = 1'b1;
        bus.reg1 = 8'h5C;
        wait_n(112);
        bus.hold = 1'b0;
        wait_n(150);
        @(posedge clk);
        #1;
        push(0, 8'hFF, 7'h7F, 1'b1, 1'b0, "async_reset");
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        push(2,  8'hFE, 7'h40, 1'b1, 1'b0, "rst_s0");
        push(6,  LZ ? 8'hFF : 8'hFD, LZ ? 7'h7F : 7'h40, 1'b1, 1'b0, "rst_s1");
        push(10, 8'hFB, 7'h40, 1'b0, 1'b0, "rst_s2");
        push(49, 8'hFF, 7'h7F, 1'b1, 1'b0, "s4_blank");
        push(50, 8'hEF, 7'h78, 1'b0, 1'b0, "reg2_lo");
        push(54, LZ ? 8'hFF : 8'hDF, LZ ? 7'h7F : 7'h40, 1'b1, 1'b0, "reg2_hi");
        push(55, LZ ? 8'hFF : 8'hDF, LZ ? 7'h7F : 7'h40, 1'b1, 1'b0, "reg2_hi_c2");
        rst_n = 1'b1;
        bus.reg2 = 8'h07;
        wait_n(60);
        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected samples left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_display_scan.md
Name: reg_display_scan

Overview:
Downstream display stage for the cpu block. It consumes the four architectural register outputs (reg0..reg3) and time-multiplexes them as eight hex digits onto a common-anode 8-digit seven-segment display. It snapshots the registers once per frame so that no digit shows a mix of old and new values. Sits at board top level between cpu and the display pins.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot; legal range >= 2.
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV; 0 disables blanking.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
reg0  in  8  cpu register 0
reg1  in  8  cpu register 1
reg2  in  8  cpu register 2
reg3  in  8  cpu register 3
hold  in  1  1 = freeze the snapshot; the display keeps its current values
an  out  8  digit anodes, active-low, one-hot-low when a digit is lit
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. Every flop clears immediately on rst_n=0.
- Reset values:
  - an=8'hFF, seg=7'h7F, dp=1, frame_tick=0.
  - Divider cnt=0, digit index idx=0, all four shadow registers 8'h00.
- Divider:
  - cnt counts 0..REFRESH_DIV-1.
  - At terminal count, cnt returns to 0 and idx increments 0..7, wrapping from 7 to 0.
- Frame boundary: the cycle where cnt==REFRESH_DIV-1 and idx==7.
  - If hold=0, shadow[k] <= reg_k for all k, sampled in that same cycle.
  - If hold=1, the shadows keep their values.
  - frame_tick is registered. It is high for exactly the one cycle in which idx==0 and cnt==0.
  - Period is 8*REFRESH_DIV cycles.
- Digit mapping:
  - Digit i shows nibble i of {shadow3,shadow2,shadow1,shadow0}.
  - Digit 0 = shadow0[3:0], digit 1 = shadow0[7:4], digit 2 = shadow1[3:0], and so on up to digit 7 = shadow3[7:4].
- Output timing:
  - an, seg and dp are registered. They reflect the (idx,cnt) of the previous cycle, i.e. 1-cycle latency.
  - When cnt < BLANK_CYCLES: an=8'hFF, seg=7'h7F, dp=1.
  - Otherwise: an[idx]=0 and all other anode bits are 1; seg=hex(nibble).
  - dp=0 only in slots idx=2, 4, 6 (register separators); dp=1 in all other slots.
- Hex table (active-low), values 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
- After reset the display shows zeros until the first frame boundary, which occurs 8*REFRESH_DIV cycles after reset release.
- hold changing mid-frame has no effect until the next frame boundary. Register changes mid-frame are not visible until the next frame boundary.
- Reset asserted mid-frame: outputs return to their reset values immediately, the shadows are cleared, and scanning restarts at idx 0.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: for each register, if its high nibble is 0, the odd digit slot (1, 3, 5, 7) for that register holds an=8'hFF, seg=7'h7F, dp=1 for the whole slot. The low nibble is always shown.
- Undefined: all eight digits are always shown, including zero high nibbles.

Test Plan:
1. REFRESH_DIV=4, BLANK_CYCLES=1. Hold rst_n=0 -> an=FF, seg=7F, dp=1, frame_tick=0. Release with all regs 0 -> in slot 0 after the blank cycle, an=FE, seg=40.
2. reg0=8'h3A, others 0; wait one frame boundary -> slot 0: an=FE, seg=08. Slot 1: an=FD, seg=30. Blank cycle between slots: an=FF.
3. Wait 3 frames -> frame_tick is one cycle wide, period exactly 32 cycles, and coincides with idx=0, cnt=0.
4. Set hold=1 and set reg1=8'h5C; run 2 frames -> digits 2 and 3 still show 40. Set hold=0 -> after the next boundary, slot 2: seg=46, dp=0. Slot 3: seg=12, dp=1.
5. Assert rst_n=0 during slot idx=5 -> an=FF in the same cycle, shadows cleared. After release, scanning resumes at slot 0 showing 40.
6. reg2=8'h07 -> slot 4 shows seg=78, dp=0. Slot 5 shows an=FF when LEADING_ZERO_BLANK_EN is defined, and an=DF, seg=40 when it is not.
